// File: rtl/wb_sp_ram_32x512_pkg.sv
// Shared constants for the 512 x 32-bit Wishbone scratch RAM.
package wb_ram_pkg;

    localparam int unsigned ADDR_WIDTH = 11;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BYTE_LANES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH      = 2 ** (ADDR_WIDTH - 2);

    // Word index is the byte address with the lane bits dropped.
    localparam int unsigned WORD_LSB   = 2;
    localparam int unsigned WORD_MSB   = ADDR_WIDTH - 1;
    localparam int unsigned IDX_WIDTH  = WORD_MSB - WORD_LSB + 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [BYTE_LANES-1:0] sel_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;

endpackage

// File: rtl/wb_sp_ram_32x512_if.sv
// Wishbone classic bus bundle between a master and the scratch RAM.
interface wb_sp_ram_32x512_if;
    import wb_ram_pkg::*;

    addr_t addr_i;
    data_t data_i;
    logic  we_i;
    logic  cyc_i;
    logic  stb_i;
    sel_t  sel_i;
    logic  ack_o;
    data_t data_o;

    modport master (
        output addr_i, data_i, we_i, cyc_i, stb_i, sel_i,
        input  ack_o, data_o
    );

    modport slave (
        input  addr_i, data_i, we_i, cyc_i, stb_i, sel_i,
        output ack_o, data_o
    );

endinterface

// File: rtl/sp_ram_be_32x512.sv
// Single-port 512 x 32 RAM, per-byte write enables, registered read port.
module sp_ram_be_32x512
    import wb_ram_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  logic  rd_en,
    input  idx_t  idx,
    input  sel_t  be,
    input  data_t wdata,
    output data_t rdata
);

    data_t mem [DEPTH];

    // Byte-lane write; the array itself is never reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < BYTE_LANES; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read; output register clears on reset, otherwise holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/wb_sp_ram_32x512.sv
// Wishbone classic slave around a 2 KiB byte-enabled scratch RAM.
module wb_sp_ram_32x512
    import wb_ram_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    wb_sp_ram_32x512_if.slave    wb
);

    logic ack;
    logic req;
    logic wr_en;
    logic rd_en;
    idx_t idx;

    // Qualify a new transfer; the cycle after an ack never starts one.
    always_comb begin
        req   = wb.cyc_i & wb.stb_i & ~ack;
        wr_en = req & wb.we_i & ~rst_i;
        rd_en = req & ~wb.we_i & ~rst_i;
        idx   = wb.addr_i[WORD_MSB:WORD_LSB];
    end

    // One-cycle acknowledge pulse per accepted request; reset wins over a request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack <= 1'b0;
        end else begin
            ack <= req;
        end
    end

    sp_ram_be_32x512 u_ram (
        .clk   (clk_i),
        .rst   (rst_i),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .idx   (idx),
        .be    (wb.sel_i),
        .wdata (wb.data_i),
        .rdata (wb.data_o)
    );

    assign wb.ack_o = ack;

endmodule

// File: tb/tb_wb_sp_ram_32x512.sv
// Directed bench for the Wishbone scratch RAM.
module tb_wb_sp_ram_32x512;
    import wb_ram_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_sp_ram_32x512_if bus ();

    wb_sp_ram_32x512 dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wb    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.cyc_i  = 1'b0;
        bus.stb_i  = 1'b0;
        bus.we_i   = 1'b0;
        bus.sel_i  = '0;
        bus.addr_i = '0;
        bus.data_i = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Single transfer: ack expected one cycle, then low on the following edge.
    task automatic wb_write(input string tag, input logic [10:0] a, input logic [3:0] s, input logic [31:0] d);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
        bus.addr_i = a; bus.sel_i = s; bus.data_i = d;
        tick();
        check({tag, "_ack"}, {31'd0, bus.ack_o}, 32'd1);
        idle_bus();
        tick();
        check({tag, "_ackclr"}, {31'd0, bus.ack_o}, 32'd0);
    endtask

    task automatic wb_read(input string tag, input logic [10:0] a, input logic [31:0] exp);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.addr_i = a; bus.sel_i = 4'h0; bus.data_i = 32'hFFFF_FFFF;
        tick();
        check({tag, "_ack"}, {31'd0, bus.ack_o}, 32'd1);
        check({tag, "_data"}, bus.data_o, exp);
        idle_bus();
        tick();
        check({tag, "_ackclr"}, {31'd0, bus.ack_o}, 32'd0);
    endtask

    initial begin
        idle_bus();
        rst_i = 1'b1;

        // Reset held, no traffic
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ack", {31'd0, bus.ack_o}, 32'd0);
            check("rst_data", bus.data_o, 32'd0);
        end
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("idle_ack", {31'd0, bus.ack_o}, 32'd0);
            check("idle_data", bus.data_o, 32'd0);
        end

        // Basic write/read
        wb_write("w0", 11'h000, 4'hF, 32'hDEAD_BEEF);
        check("w0_nodata", bus.data_o, 32'd0);
        wb_read("r0", 11'h000, 32'hDEAD_BEEF);

        // Byte-lane merge
        wb_write("w4a", 11'h004, 4'hF, 32'h1122_3344);
        wb_write("w4b", 11'h004, 4'b0101, 32'hAABB_CCDD);
        wb_read("r4", 11'h004, 32'h11BB_33DD);

        // Top word and ignored low address bits
        wb_write("w7fc", 11'h7FC, 4'hF, 32'h1234_5678);
        wb_write("w0z", 11'h000, 4'hF, 32'h0000_0000);
        wb_read("r7fc", 11'h7FC, 32'h1234_5678);
        wb_read("r7fd", 11'h7FD, 32'h1234_5678);
        wb_read("r0z", 11'h000, 32'h0000_0000);

        // Empty byte select acks but writes nothing
        wb_write("wsel0", 11'h000, 4'h0, 32'hFFFF_FFFF);
        wb_read("rsel0", 11'h000, 32'h0000_0000);

        // Strobe without cycle: no ack
        bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.sel_i = 4'hF;
        bus.addr_i = 11'h000; bus.data_i = 32'h0BAD_0BAD;
        tick();
        check("nocyc_ack", {31'd0, bus.ack_o}, 32'd0);
        idle_bus();
        tick();
        wb_read("rnocyc", 11'h000, 32'h0000_0000);

        // Back-to-back reads with strobe held: ack 1,0,1
        wb_write("w8", 11'h008, 4'hF, 32'hA5A5_A5A5);
        wb_write("wc", 11'h00C, 4'hF, 32'h5A5A_1234);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 11'h008;
        tick();
        check("b2b_ack1", {31'd0, bus.ack_o}, 32'd1);
        check("b2b_data1", bus.data_o, 32'hA5A5_A5A5);
        bus.addr_i = 11'h00C;
        tick();
        check("b2b_ack2", {31'd0, bus.ack_o}, 32'd0);
        check("b2b_hold", bus.data_o, 32'hA5A5_A5A5);
        tick();
        check("b2b_ack3", {31'd0, bus.ack_o}, 32'd1);
        check("b2b_data3", bus.data_o, 32'h5A5A_1234);
        idle_bus();
        tick();
        check("b2b_ackclr", {31'd0, bus.ack_o}, 32'd0);

        // Reset coincident with a write: discarded, memory preserved
        wb_write("w10", 11'h010, 4'hF, 32'hCAFE_F00D);
        wb_read("r10pre", 11'h010, 32'hCAFE_F00D);
        rst_i = 1'b1;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
        bus.addr_i = 11'h010; bus.sel_i = 4'hF; bus.data_i = 32'h55AA_55AA;
        tick();
        check("rstw_ack", {31'd0, bus.ack_o}, 32'd0);
        check("rstw_data", bus.data_o, 32'd0);
        idle_bus();
        rst_i = 1'b0;
        tick();
        check("rstw_ack2", {31'd0, bus.ack_o}, 32'd0);
        wb_read("r10post", 11'h010, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
